unified_mem_arbiter: RTL and testbench

- Shares one single-ported unified memory between the instruction-fetch (IF) stage and the MEM stage of the armv8_pipelined datapath.
- Arbitrates between the two, sequences each fixed-latency memory access, and returns read data with a one-cycle ready pulse.
- Drives a combined pipeline_stall output that the hazard logic uses to freeze the pipeline.
- Also handles IF fetch cancellation on branch flush.

---
 rtl/unified_mem_arbiter_pkg.sv | 25 ++
 rtl/unified_mem_arbiter_if.sv | 53 +++++
 rtl/unified_mem_arbiter_timer.sv | 42 ++++
 rtl/unified_mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pkg
// Purpose : Shared types and default widths for the unified memory arbiter.
// Rev     : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 64;
    localparam int DEF_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } arb_gnt_e;

endpackage
`default_nettype wire

// File: rtl/unified_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : unified_mem_arbiter_if
// Purpose : IF/MEM request buses, RAM port and stall for the memory arbiter.
// Rev     : 1.0  initial release
// ============================================================================
interface unified_mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_cancel;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              pipeline_stall;

    // Requesters and the RAM sit on the master side.
    modport master (
        output if_req, if_addr, if_cancel,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output ram_rdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        input  pipeline_stall
    );

    modport slave (
        input  if_req, if_addr, if_cancel,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  ram_rdata,
        output if_rdata, if_ready, mem_rdata, mem_ready,
        output ram_en, ram_we, ram_addr, ram_wdata,
        output pipeline_stall
    );
endinterface
`default_nettype wire

// File: rtl/unified_mem_arbiter_timer.sv
`default_nettype none
// ============================================================================
// Module  : arb_latency_timer
// Purpose : Loadable down-counter with a done flag (count has reached zero).
// Rev     : 1.0  initial release
// ============================================================================
module arb_latency_timer #(
    parameter  int MAX_COUNT = 2,
    localparam int CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : unified_mem_arbiter
// Purpose : Arbitrates IF and MEM onto one fixed-latency single-ported RAM.
// Rev     : 1.0  initial release
// ============================================================================
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RAM_LAT    = 2,
    parameter int MAX_STARVE = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    unified_mem_arbiter_if.slave  bus
);

    localparam int               LAT_W   = $clog2(RAM_LAT + 1);
    localparam int               STV_W   = $clog2(MAX_STARVE + 1);
    localparam logic [LAT_W-1:0] LAT_VAL = LAT_W'(RAM_LAT);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(MAX_STARVE);

    arb_state_e        state_q,     state_d;
    arb_gnt_e          gnt_q,       gnt_d;
    logic              we_q,        we_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic [STV_W-1:0]  starve_q,    starve_d;
    logic              drop_q,      drop_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

    logic timer_load;
    logic timer_dec;
    logic timer_done;
    logic if_req_eff;
    logic if_owner;

    // A flushed fetch is not a request.
    assign if_req_eff = bus.if_req & ~bus.if_cancel;
    assign if_owner   = (gnt_q == GNT_IF);

    arb_latency_timer #(
        .MAX_COUNT (RAM_LAT)
    ) u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_i     (timer_load),
        .load_val_i (LAT_VAL),
        .dec_i      (timer_dec),
        .done_o     (timer_done)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        starve_d    = starve_q;
        drop_d      = drop_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        timer_load  = 1'b0;
        timer_dec   = 1'b0;

        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (bus.mem_req && !(if_req_eff && (starve_q == STV_MAX))) begin
                    gnt_d   = GNT_MEM;
                    we_d    = bus.mem_we;
                    addr_d  = bus.mem_addr;
                    wdata_d = bus.mem_wdata;
                    state_d = ISSUE;
                    if (if_req_eff && (starve_q != STV_MAX)) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (if_req_eff) begin
                    gnt_d    = GNT_IF;
                    we_d     = 1'b0;
                    addr_d   = bus.if_addr;
                    wdata_d  = '0;
                    starve_d = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                timer_load = 1'b1;
                state_d    = WAIT;
                if (if_owner && bus.if_cancel) begin
                    drop_d = 1'b1;
                end
            end
            WAIT: begin
                if (if_owner && bus.if_cancel) begin
                    drop_d = 1'b1;
                end
                if (timer_done) begin
                    state_d = RESP;
                    if (!we_q) begin
                        if (if_owner) begin
                            if_rdata_d = bus.ram_rdata;
                        end else begin
                            mem_rdata_d = bus.ram_rdata;
                        end
                    end
                end else begin
                    timer_dec = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                drop_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_IF;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            starve_q    <= '0;
            drop_q      <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            starve_q    <= starve_d;
            drop_q      <= drop_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign bus.ram_en    = (state_q == ISSUE);
    assign bus.ram_we    = bus.ram_en & we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;

    assign bus.if_ready  = (state_q == RESP) & if_owner & ~drop_q & ~bus.if_cancel;
    assign bus.mem_ready = (state_q == RESP) & ~if_owner;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_rdata = mem_rdata_q;

    assign bus.pipeline_stall = (bus.if_req & ~bus.if_ready & ~bus.if_cancel)
                              | (bus.mem_req & ~bus.mem_ready);

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_unified_mem_arbiter
// Purpose : Directed self-checking bench for unified_mem_arbiter (RAM_LAT 2/1/15).
// Rev     : 1.0  initial release
// ============================================================================
module tb_unified_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int LAT0  = 2;
    localparam int LAT1  = 1;
    localparam int LAT15 = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifc0  ();
    unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifc1  ();
    unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifc15 ();

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(LAT0), .MAX_STARVE(4)) dut0 (
        .clock(clk), .reset_n(rst_n), .bus(ifc0.slave));
    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(LAT1), .MAX_STARVE(4)) dut1 (
        .clock(clk), .reset_n(rst_n), .bus(ifc1.slave));
    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(LAT15), .MAX_STARVE(4)) dut15 (
        .clock(clk), .reset_n(rst_n), .bus(ifc15.slave));

    // RAM model: word array; read data appears RAM_LAT edges after the sampling edge.
    logic [63:0] ram [0:255];
    logic [63:0] pend0, pend1, pend15;
    int          left0, left1, left15;
    localparam logic [63:0] JUNK = 64'hBADB_ADBA_DBAD_BADB;

    always @(posedge clk) begin
        if (!rst_n) begin
            left0 <= 0; ifc0.ram_rdata <= '0;
        end else if (ifc0.ram_en) begin
            if (ifc0.ram_we) ram[ifc0.ram_addr[10:3]] <= ifc0.ram_wdata;
            else begin
                pend0 <= ram[ifc0.ram_addr[10:3]]; left0 <= LAT0; ifc0.ram_rdata <= JUNK;
            end
        end else if (left0 != 0) begin
            left0 <= left0 - 1;
            if (left0 == 1) ifc0.ram_rdata <= pend0;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            left1 <= 0; ifc1.ram_rdata <= '0;
        end else if (ifc1.ram_en) begin
            pend1 <= ram[ifc1.ram_addr[10:3]]; left1 <= LAT1; ifc1.ram_rdata <= JUNK;
        end else if (left1 != 0) begin
            left1 <= left1 - 1;
            if (left1 == 1) ifc1.ram_rdata <= pend1;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            left15 <= 0; ifc15.ram_rdata <= '0;
        end else if (ifc15.ram_en) begin
            pend15 <= ram[ifc15.ram_addr[10:3]]; left15 <= LAT15; ifc15.ram_rdata <= JUNK;
        end else if (left15 != 0) begin
            left15 <= left15 - 1;
            if (left15 == 1) ifc15.ram_rdata <= pend15;
        end
    end

    // One access on dut0; requires the arbiter idle and the other requester quiet.
    task automatic xact(input string tag, input bit is_if, input bit we,
                        input logic [63:0] a, input logic [63:0] wd, input logic [63:0] exp_rd);
        int lat;
        int ens;
        logic [63:0] rd;
        lat = -1; ens = 0; rd = '0;
        @(negedge clk);
        if (is_if) begin
            ifc0.if_req = 1'b1; ifc0.if_addr = a;
        end else begin
            ifc0.mem_req = 1'b1; ifc0.mem_we = we; ifc0.mem_addr = a; ifc0.mem_wdata = wd;
        end
        for (int n = 0; n < 40 && lat < 0; n++) begin
            @(negedge clk);
            if (n == 0) chk({tag, "_stall_busy"}, ifc0.pipeline_stall, 1);
            if (ifc0.ram_en) begin
                ens++;
                chk({tag, "_issue_cycle"}, n, 0);
                chk({tag, "_ram_addr"}, ifc0.ram_addr, a);
                chk({tag, "_ram_we"}, ifc0.ram_we, we);
                if (we) chk({tag, "_ram_wdata"}, ifc0.ram_wdata, wd);
            end
            if (is_if ? ifc0.if_ready : ifc0.mem_ready) begin
                lat = n;
                rd  = is_if ? ifc0.if_rdata : ifc0.mem_rdata;
                chk({tag, "_stall_ready"}, ifc0.pipeline_stall, 0);
            end
        end
        ifc0.if_req = 1'b0; ifc0.mem_req = 1'b0; ifc0.mem_we = 1'b0;
        chk({tag, "_latency"}, lat, LAT0 + 2);
        chk({tag, "_ram_en_count"}, ens, 1);
        if (!we) chk({tag, "_rdata"}, rd, exp_rd);
    endtask

    logic [63:0] gseq [6];
    logic [63:0] sseq [6];
    int exp_g [6] = '{0, 0, 0, 0, 1, 0};
    int exp_s [6] = '{1, 2, 3, 4, 0, 0};

    initial begin
        int ng, ens, rdy, r1, r15, e1, e15;
        bit done;
        logic [63:0] d1, d15;

        for (int i = 0; i < 256; i++) ram[i] = 64'h1111_0000_0000_0000 + 64'(i);
        ram[8] = 64'hDEAD_BEEF;
        ifc0.if_req = 0; ifc0.if_addr = '0; ifc0.if_cancel = 0;
        ifc0.mem_req = 0; ifc0.mem_we = 0; ifc0.mem_addr = '0; ifc0.mem_wdata = '0;
        ifc1.if_req = 0; ifc1.if_addr = '0; ifc1.if_cancel = 0;
        ifc1.mem_req = 0; ifc1.mem_we = 0; ifc1.mem_addr = '0; ifc1.mem_wdata = '0;
        ifc15.if_req = 0; ifc15.if_addr = '0; ifc15.if_cancel = 0;
        ifc15.mem_req = 0; ifc15.mem_we = 0; ifc15.mem_addr = '0; ifc15.mem_wdata = '0;

        repeat (3) @(negedge clk);
        chk("rst_ram_en", ifc0.ram_en, 0);
        chk("rst_if_ready", ifc0.if_ready, 0);
        chk("rst_mem_ready", ifc0.mem_ready, 0);
        chk("rst_ram_addr", ifc0.ram_addr, 0);
        chk("rst_state", dut0.state_q, IDLE);
        rst_n = 1'b1;

        // Basic reads and a write, then read the written word back.
        xact("if_rd40", 1, 0, 64'h40, 64'h0, 64'hDEAD_BEEF);
        xact("mem_rd200", 0, 0, 64'h200, 64'h0, 64'h1111_0000_0000_0040);
        xact("mem_wr100", 0, 1, 64'h100, 64'h1234, 64'h0);
        chk("wr_keeps_mem_rdata", ifc0.mem_rdata, 64'h1111_0000_0000_0040);
        xact("mem_rd100", 0, 0, 64'h100, 64'h0, 64'h1234);

        // Both requesters held: MEM x4, forced IF, then MEM.
        for (int i = 0; i < 6; i++) begin gseq[i] = 'x; sseq[i] = 'x; end
        @(negedge clk);
        ifc0.if_req = 1; ifc0.if_addr = 64'h300;
        ifc0.mem_req = 1; ifc0.mem_we = 0; ifc0.mem_addr = 64'h400;
        ng = 0; done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (ifc0.ram_en && ng < 6) begin
                gseq[ng] = (ifc0.ram_addr == 64'h300) ? 64'd1 : 64'd0;
                sseq[ng] = 64'(dut0.starve_q);
                ng++;
            end
            if (ifc0.if_ready) ifc0.if_req = 0;
            if (ifc0.mem_ready && ng >= 6) begin ifc0.mem_req = 0; done = 1; end
        end
        chk("arb_done", done, 1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("arb_grant%0d_is_if", i), gseq[i], exp_g[i]);
            chk($sformatf("arb_starve%0d", i), sseq[i], exp_s[i]);
        end

        // Cancel during WAIT of an IF access.
        @(negedge clk);
        ifc0.if_req = 1; ifc0.if_addr = 64'h80;
        ens = 0; rdy = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (ifc0.ram_en) ens++;
            if (ifc0.if_ready) rdy++;
            if (n == 2) begin chk("cxl_drop_set", dut0.drop_q, 1); ifc0.if_cancel = 0; end
            if (n == LAT0 + 3) chk("cxl_back_idle", dut0.state_q, IDLE);
            if (n == 1) begin ifc0.if_cancel = 1; ifc0.if_req = 0; end
        end
        chk("cxl_ram_en_count", ens, 1);
        chk("cxl_no_ready", rdy, 0);
        xact("after_cxl", 1, 0, 64'h40, 64'h0, 64'hDEAD_BEEF);

        // Asynchronous reset in the middle of WAIT.
        @(negedge clk);
        ifc0.if_req = 1; ifc0.if_addr = 64'h80;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", dut0.state_q, IDLE);
        chk("arst_ram_en", ifc0.ram_en, 0);
        chk("arst_ram_addr", ifc0.ram_addr, 0);
        chk("arst_if_rdata", ifc0.if_rdata, 0);
        chk("arst_mem_rdata", ifc0.mem_rdata, 0);
        chk("arst_if_ready", ifc0.if_ready, 0);
        ifc0.if_req = 0;
        @(negedge clk);
        rst_n = 1'b1;
        xact("post_rst_if", 1, 0, 64'h40, 64'h0, 64'hDEAD_BEEF);

        // RAM_LAT sweep: IF read on the LAT=1 and LAT=15 instances.
        @(negedge clk);
        ifc1.if_req = 1; ifc1.if_addr = 64'h40;
        ifc15.if_req = 1; ifc15.if_addr = 64'h80;
        r1 = -1; r15 = -1; e1 = 0; e15 = 0; d1 = '0; d15 = '0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (ifc1.ram_en) e1++;
            if (ifc15.ram_en) e15++;
            if (ifc1.if_ready) begin
                if (r1 < 0) begin r1 = n; d1 = ifc1.if_rdata; end
                ifc1.if_req = 0;
            end
            if (ifc15.if_ready) begin
                if (r15 < 0) begin r15 = n; d15 = ifc15.if_rdata; end
                ifc15.if_req = 0;
            end
        end
        chk("lat1_latency", r1, LAT1 + 2);
        chk("lat1_ram_en_count", e1, 1);
        chk("lat1_rdata", d1, 64'hDEAD_BEEF);
        chk("lat15_latency", r15, LAT15 + 2);
        chk("lat15_ram_en_count", e15, 1);
        chk("lat15_rdata", d15, 64'h1111_0000_0000_0010);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
